fb_write_queue: RTL and testbench

FB_WRITE_QUEUE -- requirements
Module: fb_write_queue

---
 rtl/fb_pkg.sv | 13 +
 rtl/fb_write_queue_if.sv | 28 ++
 rtl/fb_wq_fifo.sv | 46 ++++
 rtl/fb_write_queue.sv | 130 +++++++++++++
 tb/tb_fb_write_queue.sv | 273 +++++++++++++++++++++++++++
 5 files changed

// File: rtl/fb_pkg.sv
// Shared types and widths for the frame-buffer write queue.
package fb_pkg;

  localparam int unsigned FB_AW = 12;
  localparam int unsigned FB_DW = 12;

  typedef enum logic [1:0] {
    StIdle  = 2'd0,
    StDrain = 2'd1,
    StClear = 2'd2
  } fb_wq_state_e;

endpackage

// File: rtl/fb_write_queue_if.sv
// Frame-buffer RAM write port: the write queue is master, the raster arbiter is slave.
interface fb_write_queue_if
  import fb_pkg::*;
#(
  parameter int unsigned AW = FB_AW,
  parameter int unsigned DW = FB_DW
);

  logic          ram_req;
  logic          ram_gnt;
  logic [AW-1:0] ram_addr;
  logic [DW-1:0] ram_wdata;

  modport master (
    output ram_req,
    output ram_addr,
    output ram_wdata,
    input  ram_gnt
  );

  modport slave (
    input  ram_req,
    input  ram_addr,
    input  ram_wdata,
    output ram_gnt
  );

endinterface

// File: rtl/fb_wq_fifo.sv
// Show-ahead FIFO for queued frame-buffer writes; pointers carry one extra wrap bit.
module fb_wq_fifo #(
  parameter int unsigned DEPTH = 8,
  parameter int unsigned WIDTH = 24
) (
  input  logic             clk_pixel,
  input  logic             rst_pixel,
  input  logic             i_push,
  input  logic             i_pop,
  input  logic [WIDTH-1:0] i_wdata,
  output logic [WIDTH-1:0] o_rdata,
  output logic             o_full,
  output logic             o_empty,
  output logic             o_last
);

  localparam int unsigned IW = $clog2(DEPTH);
  localparam int unsigned PW = IW + 1;

  logic [WIDTH-1:0] r_mem [DEPTH];
  logic [PW-1:0]    r_wr_ptr;
  logic [PW-1:0]    r_rd_ptr;
  logic [PW-1:0]    w_count;

  always_ff @(posedge clk_pixel) begin
    if (rst_pixel) begin
      r_wr_ptr <= '0;
      r_rd_ptr <= '0;
    end else begin
      if (i_push) r_wr_ptr <= r_wr_ptr + PW'(1);
      if (i_pop)  r_rd_ptr <= r_rd_ptr + PW'(1);
    end
  end

  // Storage needs no reset; pointers alone define which entries are live.
  always_ff @(posedge clk_pixel) begin
    if (i_push) r_mem[r_wr_ptr[IW-1:0]] <= i_wdata;
  end

  assign w_count = r_wr_ptr - r_rd_ptr;
  assign o_rdata = r_mem[r_rd_ptr[IW-1:0]];
  assign o_empty = (r_wr_ptr == r_rd_ptr);
  assign o_full  = (r_wr_ptr[IW] != r_rd_ptr[IW]) && (r_wr_ptr[IW-1:0] == r_rd_ptr[IW-1:0]);
  assign o_last  = (w_count == PW'(1));

endmodule

// File: rtl/fb_write_queue.sv
// Frame-buffer write queue: buffers pixel writes, drains them to RAM, and sweeps the buffer to 0.
// Define FB_WQ_STATS_EN to add the saturating drop_cnt output.
module fb_write_queue
  import fb_pkg::*;
#(
  parameter int unsigned DEPTH = 8,
  parameter int unsigned AW    = FB_AW,
  parameter int unsigned DW    = FB_DW
) (
  input  logic              clk_pixel,
  input  logic              rst_pixel,
  input  logic [AW-1:0]     vid_fb_addr,
  input  logic [DW-1:0]     vid_fb_data,
  input  logic              vid_fb_we,
  input  logic              clr_start,
  fb_write_queue_if.master  ram_if,
  output logic              clr_busy,
  output logic              q_empty,
  output logic              ovf_sticky
`ifdef FB_WQ_STATS_EN
  ,
  output logic [15:0]       drop_cnt
`endif
);

  fb_wq_state_e     r_state;
  fb_wq_state_e     w_state_next;
  logic [AW-1:0]    r_clr_cnt;
  logic [AW-1:0]    w_clr_cnt_next;
  logic             r_clr_pend;
  logic             w_clr_pend_next;
  logic             r_ovf;
  logic             w_push;
  logic             w_pop;
  logic             w_drop;
  logic             w_full;
  logic             w_empty;
  logic             w_last;
  logic [AW+DW-1:0] w_head;

  // A pop frees the slot the same cycle, so a push into a full queue is still accepted then.
  assign w_pop  = (r_state == StDrain) && ram_if.ram_gnt;
  assign w_push = vid_fb_we && (!w_full || w_pop);
  assign w_drop = vid_fb_we && w_full && !w_pop;

  fb_wq_fifo #(
    .DEPTH (DEPTH),
    .WIDTH (AW + DW)
  ) u_fifo (
    .clk_pixel (clk_pixel),
    .rst_pixel (rst_pixel),
    .i_push    (w_push),
    .i_pop     (w_pop),
    .i_wdata   ({vid_fb_addr, vid_fb_data}),
    .o_rdata   (w_head),
    .o_full    (w_full),
    .o_empty   (w_empty),
    .o_last    (w_last)
  );

  always_comb begin
    w_state_next     = r_state;
    w_clr_cnt_next   = r_clr_cnt;
    w_clr_pend_next  = r_clr_pend;
    ram_if.ram_req   = 1'b0;
    ram_if.ram_addr  = '0;
    ram_if.ram_wdata = '0;
    clr_busy         = 1'b0;
    unique case (r_state)
      StIdle: begin
        if (clr_start || r_clr_pend) begin
          w_state_next    = StClear;
          w_clr_cnt_next  = '0;
          w_clr_pend_next = 1'b0;
        end else if (!w_empty) begin
          w_state_next = StDrain;
        end
      end
      StDrain: begin
        ram_if.ram_req   = 1'b1;
        ram_if.ram_addr  = w_head[AW+DW-1:DW];
        ram_if.ram_wdata = w_head[DW-1:0];
        if (clr_start) w_clr_pend_next = 1'b1;
        if (w_pop && w_last && !w_push) w_state_next = StIdle;
      end
      StClear: begin
        ram_if.ram_req  = 1'b1;
        ram_if.ram_addr = r_clr_cnt;
        clr_busy        = 1'b1;
        if (ram_if.ram_gnt) begin
          w_clr_cnt_next = r_clr_cnt + AW'(1);
          if (&r_clr_cnt) w_state_next = StIdle;
        end
      end
      default: w_state_next = StIdle;
    endcase
  end

  always_ff @(posedge clk_pixel) begin
    if (rst_pixel) begin
      r_state    <= StIdle;
      r_clr_cnt  <= '0;
      r_clr_pend <= 1'b0;
      r_ovf      <= 1'b0;
    end else begin
      r_state    <= w_state_next;
      r_clr_cnt  <= w_clr_cnt_next;
      r_clr_pend <= w_clr_pend_next;
      r_ovf      <= r_ovf | w_drop;
    end
  end

  assign q_empty    = w_empty;
  assign ovf_sticky = r_ovf;

`ifdef FB_WQ_STATS_EN
  logic [15:0] r_drop_cnt;

  always_ff @(posedge clk_pixel) begin
    if (rst_pixel) begin
      r_drop_cnt <= '0;
    end else if (w_drop && (r_drop_cnt != 16'hFFFF)) begin
      r_drop_cnt <= r_drop_cnt + 16'd1;
    end
  end

  assign drop_cnt = r_drop_cnt;
`endif

endmodule

// File: tb/tb_fb_write_queue.sv
// Directed bench for fb_write_queue: vector table for single write/overflow, sequences for clears.
module tb_fb_write_queue;

  typedef struct {
    logic        we;
    logic [11:0] addr;
    logic [11:0] data;
    logic        gnt;
    logic        clr;
    logic        exp_req;
    logic [11:0] exp_addr;
    logic [11:0] exp_wdata;
    logic        exp_empty;
    logic        exp_ovf;
  } vec_t;

  logic        clk = 1'b0;
  logic        rst;
  logic [11:0] vid_addr;
  logic [11:0] vid_data;
  logic        vid_we;
  logic        clr;
  logic        clr_busy;
  logic        q_empty;
  logic        ovf;
`ifdef FB_WQ_STATS_EN
  logic [15:0] drop_cnt;
`endif

  int          checks = 0;
  int          errors = 0;
  vec_t        vecs[$];
  logic [11:0] rec [16];

  fb_write_queue_if #(.AW(12), .DW(12)) u_bus ();

  fb_write_queue #(
    .DEPTH (8),
    .AW    (12),
    .DW    (12)
  ) dut (
    .clk_pixel   (clk),
    .rst_pixel   (rst),
    .vid_fb_addr (vid_addr),
    .vid_fb_data (vid_data),
    .vid_fb_we   (vid_we),
    .clr_start   (clr),
    .ram_if      (u_bus),
    .clr_busy    (clr_busy),
    .q_empty     (q_empty),
    .ovf_sticky  (ovf)
`ifdef FB_WQ_STATS_EN
    ,
    .drop_cnt    (drop_cnt)
`endif
  );

  always #5 clk = ~clk;

  initial begin
    #1000000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog");
  end

  function automatic vec_t mk(input logic we, input logic [11:0] a, input logic [11:0] d,
                              input logic g, input logic c, input logic er,
                              input logic [11:0] ea, input logic [11:0] ew,
                              input logic ee, input logic eo);
    vec_t v;
    v.we = we; v.addr = a; v.data = d; v.gnt = g; v.clr = c;
    v.exp_req = er; v.exp_addr = ea; v.exp_wdata = ew; v.exp_empty = ee; v.exp_ovf = eo;
    return v;
  endfunction

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic check(input string name, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", name, got, exp);
    end
  endtask

  task automatic do_reset();
    rst = 1'b1; vid_we = 1'b0; vid_addr = '0; vid_data = '0; clr = 1'b0;
    u_bus.ram_gnt = 1'b0;
    tick();
    tick();
    rst = 1'b0;
  endtask

  // Follows a clear sweep from its first cycle until clr_busy drops.
  task automatic run_sweep(input int push_at, input int clr_at, output int n, output int bad);
    n = 0;
    bad = 0;
    while (clr_busy && n < 5000) begin
      if (!u_bus.ram_req || u_bus.ram_addr != 12'(n) || u_bus.ram_wdata != 12'h000) bad++;
      vid_we   = (n == push_at);
      vid_addr = 12'h010;
      vid_data = 12'h777;
      clr      = (n == clr_at);
      tick();
      n++;
    end
    vid_we = 1'b0;
    clr    = 1'b0;
  endtask

  initial begin
    int n;
    int bad;
    int cnt;
    int c;
    logic hit;

    // Single write with grant held high, then 9 pushes into an ungranted DEPTH=8 queue.
    vecs.push_back(mk(1, 12'h123, 12'hABC, 1, 0, 0, 12'h000, 12'h000, 0, 0));
    vecs.push_back(mk(0, 12'h000, 12'h000, 1, 0, 1, 12'h123, 12'hABC, 0, 0));
    vecs.push_back(mk(0, 12'h000, 12'h000, 1, 0, 0, 12'h000, 12'h000, 1, 0));
    vecs.push_back(mk(0, 12'h000, 12'h000, 1, 0, 0, 12'h000, 12'h000, 1, 0));
    vecs.push_back(mk(1, 12'h001, 12'h101, 0, 0, 0, 12'h000, 12'h000, 0, 0));
    for (int i = 2; i <= 9; i++)
      vecs.push_back(mk(1, 12'(i), 12'(256 + i), 0, 0, 1, 12'h001, 12'h101, 0, logic'(i == 9)));
    vecs.push_back(mk(0, 12'h000, 12'h000, 0, 0, 1, 12'h001, 12'h101, 0, 1));
    for (int i = 2; i <= 8; i++)
      vecs.push_back(mk(0, 12'h000, 12'h000, 1, 0, 1, 12'(i), 12'(256 + i), 0, 1));
    vecs.push_back(mk(0, 12'h000, 12'h000, 1, 0, 0, 12'h000, 12'h000, 1, 1));
    vecs.push_back(mk(0, 12'h000, 12'h000, 1, 0, 0, 12'h000, 12'h000, 1, 1));

    do_reset();
    check("rst_req", 32'(u_bus.ram_req), 0);
    check("rst_addr", 32'(u_bus.ram_addr), 0);
    check("rst_wdata", 32'(u_bus.ram_wdata), 0);
    check("rst_busy", 32'(clr_busy), 0);
    check("rst_empty", 32'(q_empty), 1);
    check("rst_ovf", 32'(ovf), 0);

    foreach (vecs[k]) begin
      vid_we = vecs[k].we; vid_addr = vecs[k].addr; vid_data = vecs[k].data;
      u_bus.ram_gnt = vecs[k].gnt; clr = vecs[k].clr;
      tick();
      check($sformatf("v%0d_req", k), 32'(u_bus.ram_req), 32'(vecs[k].exp_req));
      check($sformatf("v%0d_addr", k), 32'(u_bus.ram_addr), 32'(vecs[k].exp_addr));
      check($sformatf("v%0d_wdata", k), 32'(u_bus.ram_wdata), 32'(vecs[k].exp_wdata));
      check($sformatf("v%0d_empty", k), 32'(q_empty), 32'(vecs[k].exp_empty));
      check($sformatf("v%0d_ovf", k), 32'(ovf), 32'(vecs[k].exp_ovf));
    end
`ifdef FB_WQ_STATS_EN
    check("drop_cnt", 32'(drop_cnt), 1);
`endif

    // Full queue: push lands with a grant pop and must be kept without overflow.
    do_reset();
    for (int i = 0; i < 8; i++) begin
      vid_we = 1'b1; vid_addr = 12'(32 + i); vid_data = 12'(768 + i);
      tick();
    end
    vid_we = 1'b1; vid_addr = 12'h030; vid_data = 12'h330; u_bus.ram_gnt = 1'b1;
    tick();
    vid_we = 1'b0; u_bus.ram_gnt = 1'b0;
    check("fullpp_ovf", 32'(ovf), 0);
    check("fullpp_head", 32'(u_bus.ram_addr), 32'h021);
    vid_we = 1'b1; vid_addr = 12'h03F;
    tick();
    vid_we = 1'b0;
    check("fullpp_still_full", 32'(ovf), 1);
    u_bus.ram_gnt = 1'b1;
    cnt = 0;
    for (int k = 0; k < 40; k++) begin
      if (!u_bus.ram_req && q_empty) break;
      if (u_bus.ram_req && cnt < 16) begin
        rec[cnt] = u_bus.ram_addr;
        cnt++;
      end
      tick();
    end
    check("fullpp_cnt", 32'(cnt), 8);
    check("fullpp_first", 32'(rec[0]), 32'h021);
    check("fullpp_7th", 32'(rec[6]), 32'h027);
    check("fullpp_last", 32'(rec[7]), 32'h030);

    // Clear sweep with a push in the middle that must land after address 0xFFF.
    do_reset();
    u_bus.ram_gnt = 1'b1; clr = 1'b1;
    tick();
    clr = 1'b0;
    check("clr_busy_rise", 32'(clr_busy), 1);
    check("clr_first_addr", 32'(u_bus.ram_addr), 0);
    run_sweep(5, -1, n, bad);
    check("clr_len", 32'(n), 4096);
    check("clr_seq_bad", 32'(bad), 0);
    check("clr_end_req", 32'(u_bus.ram_req), 0);
    check("clr_end_pending", 32'(q_empty), 0);
    tick();
    check("clr_post_req", 32'(u_bus.ram_req), 1);
    check("clr_post_addr", 32'(u_bus.ram_addr), 32'h010);
    check("clr_post_data", 32'(u_bus.ram_wdata), 32'h777);
    tick();
    check("clr_post_empty", 32'(q_empty), 1);

    // clr_start during DRAIN is held until the queue drains; a second one during CLEAR is ignored.
    do_reset();
    vid_we = 1'b1;
    for (int i = 0; i < 3; i++) begin
      vid_addr = 12'(65 + i); vid_data = 12'(1024 + i);
      tick();
    end
    vid_we = 1'b0; clr = 1'b1;
    tick();
    clr = 1'b0; u_bus.ram_gnt = 1'b1;
    cnt = 0; hit = 1'b0;
    for (int k = 0; k < 20; k++) begin
      if (clr_busy) begin
        hit = 1'b1;
        break;
      end
      if (u_bus.ram_req && cnt < 16) begin
        rec[cnt] = u_bus.ram_addr;
        cnt++;
      end
      tick();
    end
    check("pend_hit", 32'(hit), 1);
    check("pend_cnt", 32'(cnt), 3);
    check("pend_d0", 32'(rec[0]), 32'h041);
    check("pend_d2", 32'(rec[2]), 32'h043);
    run_sweep(-1, 100, n, bad);
    check("pend_len", 32'(n), 4096);
    check("pend_seq_bad", 32'(bad), 0);
    c = 0;
    for (int k = 0; k < 6; k++) begin
      if (clr_busy || u_bus.ram_req) c++;
      tick();
    end
    check("pend_one_sweep", 32'(c), 0);

    // Reset in the middle of a sweep drops the sweep and the queued write.
    do_reset();
    u_bus.ram_gnt = 1'b1; clr = 1'b1;
    tick();
    clr = 1'b0;
    c = 0;
    while (u_bus.ram_addr != 12'h200 && c < 1000) begin
      vid_we = (c == 3); vid_addr = 12'h055; vid_data = 12'h555;
      tick();
      c++;
    end
    vid_we = 1'b0;
    check("rstmid_reach", 32'(u_bus.ram_addr), 32'h200);
    check("rstmid_pre_empty", 32'(q_empty), 0);
    rst = 1'b1;
    tick();
    rst = 1'b0;
    check("rstmid_req", 32'(u_bus.ram_req), 0);
    check("rstmid_busy", 32'(clr_busy), 0);
    check("rstmid_empty", 32'(q_empty), 1);
    c = 0;
    for (int k = 0; k < 8; k++) begin
      tick();
      if (u_bus.ram_req || clr_busy) c++;
    end
    check("rstmid_quiet", 32'(c), 0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
